// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if
// Groups the time inputs coming from the counter chain and the scanned
// display outputs. "master" drives the time values and observes the display.
// "slave" is the view used by the display stage itself.
interface seg_scan_display_if;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       colon;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_sel;
    logic       frame_start;

    modport master (
        output sec, min, hour, colon,
        input  seg, dp, dig_sel, frame_start
    );

    modport slave (
        input  sec, min, hour, colon,
        output seg, dp, dig_sel, frame_start
    );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display
// Six-digit multiplexed 7-segment driver for the digital clock.
// Converts binary sec/min/hour to BCD and scans the digits at CLK_DIV cycles
// per slot. The first BLANK_CYC cycles of each slot are blanked to stop
// ghosting. The inputs are sampled once per frame, so every digit of a frame
// comes from the same time value.
// Optional build macro: LEAD_ZERO_BLANK_EN blanks the hour-tens digit when
// hour < 10. Dashes for out-of-range values still take priority.
module seg_scan_display #(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input logic              clk,
    input logic              rst,
    seg_scan_display_if.slave bus
);

    localparam int             PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  BLANK_END  = PW'(BLANK_CYC);
    localparam logic [6:0]     SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic           DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [5:0]     DIG_OFF    = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;
    localparam logic [6:0]     SEG_DASH   = 7'b1000000;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          first_frame;
    logic          capture;

    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [4:0]    snap_hour;
    logic          snap_colon;

    logic          sec_bad;
    logic          min_bad;
    logic          hour_bad;
    logic [3:0]    digit_val;
    logic          digit_bad;
    logic          digit_blank;
    logic [6:0]    seg_lit;
    logic          dp_lit;
    logic [5:0]    sel_onehot;

    // Segment pattern {g..a} for one BCD digit, 1 = lit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0111111;
            4'd1:    seg_code = 7'b0000110;
            4'd2:    seg_code = 7'b1011011;
            4'd3:    seg_code = 7'b1001111;
            4'd4:    seg_code = 7'b1100110;
            4'd5:    seg_code = 7'b1101101;
            4'd6:    seg_code = 7'b1111101;
            4'd7:    seg_code = 7'b0000111;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1101111;
            default: seg_code = 7'b0000000;
        endcase
    endfunction

    // A new snapshot is taken on the last cycle of digit 5, or on the first cycle after reset.
    assign capture = first_frame || ((presc == PRESC_LAST) && (idx == 3'd5));

    // Slot prescaler and digit index advancing 0..5 on each prescaler wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            idx         <= 3'd0;
            first_frame <= 1'b1;
        end else begin
            first_frame <= 1'b0;
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Frame-coherent snapshot of the time inputs plus the matching frame_start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_sec        <= '0;
            snap_min        <= '0;
            snap_hour       <= '0;
            snap_colon      <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= capture;
            if (capture) begin
                snap_sec   <= bus.sec;
                snap_min   <= bus.min;
                snap_hour  <= bus.hour;
                snap_colon <= bus.colon;
            end
        end
    end

    // Select the BCD digit for the current index and turn it into a lit pattern.
    always_comb begin
        sec_bad     = snap_sec > 6'd59;
        min_bad     = snap_min > 6'd59;
        hour_bad    = snap_hour > 5'd23;
        digit_val   = 4'd0;
        digit_bad   = 1'b0;
        digit_blank = 1'b0;
        case (idx)
            3'd0: begin
                digit_val = 4'(snap_sec % 6'd10);
                digit_bad = sec_bad;
            end
            3'd1: begin
                digit_val = 4'(snap_sec / 6'd10);
                digit_bad = sec_bad;
            end
            3'd2: begin
                digit_val = 4'(snap_min % 6'd10);
                digit_bad = min_bad;
            end
            3'd3: begin
                digit_val = 4'(snap_min / 6'd10);
                digit_bad = min_bad;
            end
            3'd4: begin
                digit_val = 4'(snap_hour % 5'd10);
                digit_bad = hour_bad;
            end
            3'd5: begin
                digit_val = 4'(snap_hour / 5'd10);
                digit_bad = hour_bad;
`ifdef LEAD_ZERO_BLANK_EN
                digit_blank = snap_hour < 5'd10;
`else
                digit_blank = 1'b0;
`endif
            end
            default: begin
                digit_val = 4'd0;
            end
        endcase

        if (digit_bad) begin
            seg_lit = SEG_DASH;
        end else if (digit_blank) begin
            seg_lit = 7'b0000000;
        end else begin
            seg_lit = seg_code(digit_val);
        end
        dp_lit     = snap_colon && ((idx == 3'd2) || (idx == 3'd4));
        sel_onehot = 6'(6'b000001 << idx);
    end

    // Registered pin drivers: blanked during the start of each slot, polarity applied last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.seg     <= SEG_OFF;
            bus.dp      <= DP_OFF;
            bus.dig_sel <= DIG_OFF;
        end else if (presc < BLANK_END) begin
            bus.seg     <= SEG_OFF;
            bus.dp      <= DP_OFF;
            bus.dig_sel <= DIG_OFF;
        end else begin
            bus.seg     <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
            bus.dp      <= SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
            bus.dig_sel <= DIG_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
        end
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Downstream display stage for the digital clock. It consumes the binary second, minute and hour counts produced by the mod-60/mod-60/mod-24 counter chain. It converts each count to two BCD digits and time-multiplexes six common-anode/cathode 7-segment digits. A fixed-period scan provides anti-ghosting blanking and frame-coherent sampling of the inputs.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot (≥ 4)
BLANK_CYC, 16, cycles at start of each slot with all digit selects inactive (1 ≤ BLANK_CYC < CLK_DIV)
SEG_ACTIVE_LOW, 1, 1: seg/dp driven low = lit; 0: high = lit
DIG_ACTIVE_LOW, 1, 1: dig_sel low = digit enabled; 0: high = enabled

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sec  input  6  binary seconds count (valid 0..59)
min  input  6  binary minutes count (valid 0..59)
hour  input  5  binary hours count (valid 0..23)
colon  input  1  1 = light decimal points used as colon separators
seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW
dig_sel  output  6  one-hot digit enable, polarity per DIG_ACTIVE_LOW
frame_start  output  1  one-cycle pulse when the digit 0 slot begins

Behaviour:
- Reset (async, rst=1): prescaler=0, digit index=0, snapshot registers=0, frame_start=0. All outputs inactive: seg/dp unlit, dig_sel all disabled at the configured polarity.
- Prescaler counts 0..CLK_DIV-1 and wraps to 0. When the prescaler wraps, the digit index advances 0→1→…→5→0.
- Digit map: 0 = sec ones (rightmost), 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hour ones, 5 = hour tens.
- Snapshot: on the cycle the index moves 5→0, sec/min/hour/colon are captured. The first frame after reset also captures on the first cycle with rst=0. All six digits of one frame show the same snapshot; mid-frame input changes have no effect until the next frame.
- frame_start pulses high for exactly one cycle, aligned with the capture cycle.
- All outputs are registered. seg/dp/dig_sel reflect the new index one clk after the prescaler wrap.
- Blanking: for prescaler values 0..BLANK_CYC-1 of each slot, dig_sel is all disabled and seg/dp are unlit. For the remaining CLK_DIV-BLANK_CYC cycles, exactly one dig_sel bit is enabled.
- BCD: tens = v/10, ones = v%10. Range guard: if sec>59, both sec digits show dash (segment g only). The same rule applies to min>59 and to hour>23.
- Segment codes {g..a}, lit=1 before polarity:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - dash=1000000
- dp is lit only on digits 2 and 4, and only when the snapshot colon=1.
- Reset mid-slot immediately forces all outputs inactive. After release, scanning restarts from digit 0 with a fresh snapshot.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: when the snapshot hour < 10, the hour-tens digit (index 5) shows all segments unlit. Its dig_sel timing is unchanged.
- Undefined: hour-tens shows "0" for hour < 10.
- Range-guard dashes take priority in both builds.

Test Plan:
All scenarios use CLK_DIV=8, BLANK_CYC=2, both polarities=1.
1. Assert rst mid-slot. Required: seg=7'h7F, dp=1, dig_sel=6'h3F asynchronously. After release, first enabled digit is dig_sel=6'b111110 at cycle 3.
2. Drive hour=12, min=34, sec=56, colon=1 for 2 frames. Required per slot, digits 0..5:
   - seg codes (lit pattern) 6, 5, 4, 3, 2, 1
   - dp lit only on digits 2 and 4
   - each digit enabled 6 of 8 cycles
3. Drive sec=59, then change it to 0 in the middle of digit 3's slot. Required: the current frame still shows 59. The next frame (after the frame_start pulse) shows 00.
4. Drive sec=61, min=60, hour=24. Required: all six digits show dash (lit 1000000).
5. Drive hour=7. Required: digit 5 shows "0" without LEAD_ZERO_BLANK_EN, and shows all segments unlit with LEAD_ZERO_BLANK_EN defined.
6. Free-run 3 frames. Required: frame_start pulse period = 48 cycles. No cycle ever has more than one dig_sel bit enabled.
